// File: rtl/l1_dm_cache_if.sv
// Bus bundle for l1_dm_cache: CPU word port plus the physical-memory line port.
// The slave modport is the cache side; master is the core/memory environment.
interface l1_dm_cache_if #(
  parameter int LINE_BYTES = 32
);
  logic [31:0]             mem_address;
  logic                    mem_read;
  logic                    mem_write;
  logic [3:0]              mem_byte_enable;
  logic [31:0]             mem_wdata;
  logic [31:0]             mem_rdata;
  logic                    mem_resp;
  logic [31:0]             pmem_address;
  logic                    pmem_read;
  logic                    pmem_write;
  logic [8*LINE_BYTES-1:0] pmem_wdata;
  logic [8*LINE_BYTES-1:0] pmem_rdata;
  logic                    pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
           pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
           pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/l1_dm_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache. Hits complete in the
// request cycle; misses optionally write back the victim, then fill the line.
module l1_dm_cache #(
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  l1_dm_cache_if.slave  bus
);
  localparam int IDX    = $clog2(NUM_SETS);
  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int TAG_W  = 32 - OFF - IDX;
  localparam int WSEL_W = OFF - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tags [NUM_SETS];
  logic [LINE_W-1:0]   data [NUM_SETS];
  logic [TAG_W-1:0]    miss_tag;
  logic [IDX-1:0]      miss_idx;

  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  addr_tag;
  logic [WSEL_W-1:0] wsel;
  logic              req;
  logic              hit;
  logic              unused_addr_bits;

  assign idx      = bus.mem_address[OFF+IDX-1:OFF];
  assign addr_tag = bus.mem_address[31:OFF+IDX];
  assign wsel     = bus.mem_address[OFF-1:2];
  assign req      = bus.mem_read | bus.mem_write;
  assign hit      = valid[idx] && (tags[idx] == addr_tag);
  assign unused_addr_bits = ^bus.mem_address[1:0];

  // Hit response is combinational so a hit costs no extra cycle; gating on
  // rst_n keeps it quiet during the reset cycle whatever state held before.
  assign bus.mem_resp   = rst_n && (state == IDLE) && req && hit;
  assign bus.mem_rdata  = data[idx][int'(wsel)*32 +: 32];
  assign bus.pmem_wdata = data[miss_idx];

  // Control FSM; pmem_read/pmem_write/pmem_address are registered and set on
  // the transition edge so they are high from the first cycle of each state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      valid            <= '0;
      dirty            <= '0;
      miss_tag         <= '0;
      miss_idx         <= '0;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit && bus.mem_write) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            miss_tag <= addr_tag;
            miss_idx <= idx;
            if (valid[idx] && dirty[idx]) begin
              state            <= WRITEBACK;
              bus.pmem_write   <= 1'b1;
              bus.pmem_address <= {tags[idx], idx, {OFF{1'b0}}};
            end else begin
              state            <= ALLOCATE;
              bus.pmem_read    <= 1'b1;
              bus.pmem_address <= {addr_tag, idx, {OFF{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) begin
            dirty[miss_idx]  <= 1'b0;
            state            <= ALLOCATE;
            bus.pmem_write   <= 1'b0;
            bus.pmem_read    <= 1'b1;
            bus.pmem_address <= {miss_tag, miss_idx, {OFF{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            valid[miss_idx]  <= 1'b1;
            dirty[miss_idx]  <= 1'b0;
            state            <= IDLE;
            bus.pmem_read    <= 1'b0;
            bus.pmem_address <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays have no reset; valid bits alone decide whether
  // their contents mean anything, and leaving them unreset keeps them plain storage.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == IDLE && req && hit && bus.mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_byte_enable[b])
            data[idx][int'(wsel)*32 + b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
      end else if (state == ALLOCATE && bus.pmem_resp) begin
        data[miss_idx] <= bus.pmem_rdata;
        tags[miss_idx] <= miss_tag;
      end
    end
  end
endmodule

// File: tb/tb_l1_dm_cache.sv
// Directed self-checking bench for l1_dm_cache: misses, hits, write merge,
// dirty writeback, reset during a fill and simultaneous read/write.
module tb_l1_dm_cache;
  localparam int LINE_BYTES = 32;
  localparam int LINE_W     = 8 * LINE_BYTES;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   failures;

  l1_dm_cache_if #(.LINE_BYTES(LINE_BYTES)) bus ();

  l1_dm_cache #(.NUM_SETS(8), .LINE_BYTES(LINE_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] w0, input logic [31:0] w1);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = 32'h5000_0000 + i;
    l[31:0]  = w0;
    l[63:32] = w1;
    return l;
  endfunction

  task automatic cpu(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [3:0] be, input logic [31:0] wd);
    bus.mem_address     = addr;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
  endtask

  task automatic cpu_idle();
    cpu(32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_idle();
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    @(negedge clk);
    @(negedge clk); #1;
    tests_run++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL reset_mem_resp: got %b want 0", bus.mem_resp); end
    tests_run++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL reset_pmem_req: rd=%b wr=%b want 0 0", bus.pmem_read, bus.pmem_write); end
    tests_run++; if (bus.pmem_address !== 32'h0) begin failures++; $display("FAIL reset_pmem_addr: got %h want 00000000", bus.pmem_address); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    @(negedge clk);
    cpu(32'h40, 1'b1, 1'b0, 4'h0, 32'h0); #1;
    tests_run++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL miss_no_resp: got %b want 0", bus.mem_resp); end
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL miss_fill_req: rd=%b wr=%b want 1 0", bus.pmem_read, bus.pmem_write); end
    tests_run++; if (bus.pmem_address !== 32'h40) begin failures++; $display("FAIL miss_fill_addr: got %h want 00000040", bus.pmem_address); end
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_read !== 1'b1 || bus.mem_resp !== 1'b0) begin failures++; $display("FAIL miss_hold: pmem_read=%b mem_resp=%b want 1 0", bus.pmem_read, bus.mem_resp); end
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(32'hDEADBEEF, 32'hCAFEF00D);
    @(negedge clk);
    bus.pmem_resp = 1'b0; #1;
    tests_run++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL miss_resp: got %b want 1", bus.mem_resp); end
    tests_run++; if (bus.mem_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL miss_rdata: got %h want deadbeef", bus.mem_rdata); end
    tests_run++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL miss_pmem_drop: rd=%b wr=%b want 0 0", bus.pmem_read, bus.pmem_write); end
    @(negedge clk);
    cpu_idle();
  endtask

  task automatic test_read_hit();
    cpu(32'h44, 1'b1, 1'b0, 4'h0, 32'h0); #1;
    tests_run++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL hit_resp: got %b want 1", bus.mem_resp); end
    tests_run++; if (bus.mem_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL hit_rdata: got %h want cafef00d", bus.mem_rdata); end
    @(negedge clk); cpu_idle(); #1;
    tests_run++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL hit_no_pmem: rd=%b wr=%b want 0 0", bus.pmem_read, bus.pmem_write); end
  endtask

  task automatic test_write_hit();
    @(negedge clk);
    cpu(32'h40, 1'b0, 1'b1, 4'b0011, 32'h12345678); #1;
    tests_run++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL wr_hit_resp: got %b want 1", bus.mem_resp); end
    @(negedge clk);
    cpu(32'h40, 1'b1, 1'b0, 4'h0, 32'h0); #1;
    tests_run++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hDEAD5678) begin failures++; $display("FAIL wr_merge: resp=%b rdata=%h want 1 dead5678", bus.mem_resp, bus.mem_rdata); end
    @(negedge clk); cpu_idle();
  endtask

  task automatic test_dirty_miss();
    @(negedge clk);
    cpu(32'h140, 1'b1, 1'b0, 4'h0, 32'h0); #1;
    tests_run++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL dmiss_no_resp: got %b want 0", bus.mem_resp); end
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL dmiss_wb_req: wr=%b rd=%b want 1 0", bus.pmem_write, bus.pmem_read); end
    tests_run++; if (bus.pmem_address !== 32'h40) begin failures++; $display("FAIL dmiss_wb_addr: got %h want 00000040", bus.pmem_address); end
    tests_run++; if (bus.pmem_wdata[63:0] !== {32'hCAFEF00D, 32'hDEAD5678}) begin failures++; $display("FAIL dmiss_wb_data: got %h want cafef00ddead5678", bus.pmem_wdata[63:0]); end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0; #1;
    tests_run++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b1) begin failures++; $display("FAIL dmiss_fill_req: wr=%b rd=%b want 0 1", bus.pmem_write, bus.pmem_read); end
    tests_run++; if (bus.pmem_address !== 32'h140) begin failures++; $display("FAIL dmiss_fill_addr: got %h want 00000140", bus.pmem_address); end
    tests_run++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL dmiss_resp_early: got %b want 0", bus.mem_resp); end
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(32'h0BADF00D, 32'h77778888);
    @(negedge clk);
    bus.pmem_resp = 1'b0; #1;
    tests_run++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL dmiss_rdata: resp=%b rdata=%h want 1 0badf00d", bus.mem_resp, bus.mem_rdata); end
    @(negedge clk); cpu_idle();
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    cpu(32'h40, 1'b1, 1'b0, 4'h0, 32'h0);
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h40) begin failures++; $display("FAIL rst_mid_fill: rd=%b addr=%h want 1 00000040", bus.pmem_read, bus.pmem_address); end
    rst_n = 1'b0;
    cpu_idle();
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin failures++; $display("FAIL rst_mid_abort: rd=%b addr=%h want 0 00000000", bus.pmem_read, bus.pmem_address); end
    rst_n = 1'b1;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(32'h99999999, 32'h99999999);
    @(negedge clk);
    bus.pmem_resp = 1'b0; #1;
    tests_run++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.mem_resp !== 1'b0) begin failures++; $display("FAIL rst_late_resp: rd=%b wr=%b resp=%b want 0 0 0", bus.pmem_read, bus.pmem_write, bus.mem_resp); end
    cpu(32'h40, 1'b1, 1'b0, 4'h0, 32'h0); #1;
    tests_run++; if (bus.mem_resp !== 1'b0) begin failures++; $display("FAIL rst_remiss_resp: got %b want 0", bus.mem_resp); end
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin failures++; $display("FAIL rst_remiss_req: rd=%b wr=%b want 1 0", bus.pmem_read, bus.pmem_write); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(32'hDEADBEEF, 32'hCAFEF00D);
    @(negedge clk);
    bus.pmem_resp = 1'b0; #1;
    tests_run++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_refill: resp=%b rdata=%h want 1 deadbeef", bus.mem_resp, bus.mem_rdata); end
    @(negedge clk); cpu_idle();
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    cpu(32'h44, 1'b1, 1'b1, 4'b1111, 32'hA5A5A5A5); #1;
    tests_run++; if (bus.mem_resp !== 1'b1) begin failures++; $display("FAIL rw_resp: got %b want 1", bus.mem_resp); end
    @(negedge clk);
    cpu_idle(); #1;
    tests_run++; if (bus.mem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin failures++; $display("FAIL rw_single: resp=%b pmem_read=%b want 0 0", bus.mem_resp, bus.pmem_read); end
    @(negedge clk);
    cpu(32'h44, 1'b1, 1'b0, 4'h0, 32'h0); #1;
    tests_run++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL rw_readback: resp=%b rdata=%h want 1 a5a5a5a5", bus.mem_resp, bus.mem_rdata); end
    @(negedge clk); cpu_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cpu(32'h144, 1'b1, 1'b0, 4'h0, 32'h0);
    @(negedge clk); #1;
    tests_run++; if (bus.pmem_write !== 1'b1 || bus.pmem_address !== 32'h40) begin failures++; $display("FAIL b2b_wb: wr=%b addr=%h want 1 00000040", bus.pmem_write, bus.pmem_address); end
    tests_run++; if (bus.pmem_wdata[63:0] !== {32'hA5A5A5A5, 32'hDEADBEEF}) begin failures++; $display("FAIL b2b_wb_data: got %h want a5a5a5a5deadbeef", bus.pmem_wdata[63:0]); end
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = mk_line(32'h33334444, 32'h11112222); #1;
    tests_run++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h140) begin failures++; $display("FAIL b2b_fill: rd=%b addr=%h want 1 00000140", bus.pmem_read, bus.pmem_address); end
    @(negedge clk);
    bus.pmem_resp = 1'b0; #1;
    tests_run++; if (bus.mem_resp !== 1'b1 || bus.mem_rdata !== 32'h11112222) begin failures++; $display("FAIL b2b_rdata: resp=%b rdata=%h want 1 11112222", bus.mem_resp, bus.mem_rdata); end
    @(negedge clk); cpu_idle();
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_reset_mid_miss();
    test_read_write_both();
    test_back_to_back();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule

// File: doc/l1_dm_cache.md
Name: l1_dm_cache

Overview:
- Direct-mapped, write-back, write-allocate cache between the multicycle RV32I core's memory port and physical memory.
- CPU side has the core's semantics: mem_read/mem_write held until mem_resp, 32-bit words, byte enables.
- Memory side moves whole lines with a level-held request / one-cycle pmem_resp handshake.
- Tag/valid/dirty and data arrays are flops internal to the block.

Parameters:
- NUM_SETS, 8, number of lines; power of 2; index width IDX = log2(NUM_SETS).
- LINE_BYTES, 32, bytes per line; offset width OFF = log2(LINE_BYTES); line width 8*LINE_BYTES bits.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- mem_address  in  32  CPU byte address; word = mem_address[OFF-1:2]
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  4  write byte mask, bit i -> byte i of word
- mem_wdata  in  32  CPU write data
- mem_rdata  out  32  read data, valid when mem_resp=1
- mem_resp  out  1  one-cycle request completion
- pmem_address  out  32  line-aligned physical address (low OFF bits 0)
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_wdata  out  8*LINE_BYTES  writeback line
- pmem_rdata  in  8*LINE_BYTES  fill line, sampled when pmem_resp=1
- pmem_resp  in  1  physical memory completion pulse

Behaviour:
- Address split: offset [OFF-1:0], index [OFF+IDX-1:OFF], tag [31:OFF+IDX]. Defaults: index [7:5], tag [31:8].
- Reset (rst_n=0 at edge):
  - state=IDLE; all valid and dirty bits cleared.
  - Tag and data arrays not reset.
  - Outputs in reset cycle and following IDLE: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0.
  - Reset overrides any state, including mid-miss; an in-flight pmem transaction is abandoned and a late pmem_resp is ignored.
- Request: req = mem_read|mem_write. If both are high, treat as write (no read response semantics beyond mem_rdata).
- hit = valid[idx] && tag[idx]==addr tag.
- IDLE:
  - req && hit: mem_resp=1 combinationally in the same cycle; mem_rdata = selected word of line.
  - Write hit: at the edge, bytes with enable=1 are merged into the word and dirty[idx]=1; stay IDLE.
  - req && !hit && !dirty[idx]: go ALLOCATE.
  - req && !hit && valid[idx] && dirty[idx]: go WRITEBACK.
  - No req: stay; pmem_resp ignored.
- WRITEBACK:
  - pmem_write=1, pmem_address={tag[idx], idx, OFF'b0}, pmem_wdata=data[idx].
  - On pmem_resp: dirty[idx]=0, go ALLOCATE. Otherwise hold.
- ALLOCATE:
  - pmem_read=1, pmem_address={addr tag, idx, OFF'b0}.
  - On pmem_resp: data[idx]=pmem_rdata, tag written, valid=1, dirty=0, go IDLE. Otherwise hold.
- After a fill, the request re-evaluates in IDLE as a hit and gets mem_resp that cycle.
- Miss latency: 1 (IDLE) + fill cycles + 1; a dirty miss adds the writeback cycles.
- mem_resp is never asserted outside IDLE.
- CPU holds address/data stable until mem_resp. If req drops mid-miss, the miss still completes (line installed, dirty cleared if written back) and no mem_resp is issued.
- pmem_read and pmem_write are never high together. Each pmem request is asserted from state entry until the cycle of pmem_resp inclusive, deasserted the next cycle.
- mem_rdata always drives the selected word of data[idx]; it is meaningful only with mem_resp.

Test Plan:
- After reset, read 0x00000040. Expect pmem_read=1 with pmem_address 0x00000040; reply with a line whose word0=0xDEADBEEF after 3 cycles. Expect mem_resp one cycle after pmem_resp, mem_rdata=0xDEADBEEF, no pmem_write.
- Read 0x00000044 (same line, word1=0xCAFEF00D). Expect mem_resp in the request cycle, mem_rdata=0xCAFEF00D, pmem_read/pmem_write stay 0.
- Write 0x00000040, byte_enable 4'b0011, wdata 0x12345678. Expect mem_resp same cycle; then read 0x40 returns 0xDEAD5678; dirty set.
- Read 0x00000140 (index 2, tag 1, conflicts with 0x40):
  - Expect pmem_write first, address 0x00000040, pmem_wdata word0=0xDEAD5678.
  - After pmem_resp, expect pmem_read address 0x00000140, then mem_resp with the filled word.
- Reset asserted while in ALLOCATE. Expect pmem_read=0 the next cycle and a late pmem_resp ignored; a subsequent read 0x40 misses again (pmem_read issued).
- mem_read=mem_write=1 at hit address 0x44, enable 4'b1111, wdata 0xA5A5A5A5. Expect write performed, single mem_resp, and a later read returns 0xA5A5A5A5.
